// File: rtl/cpu_test_ctrl.sv
// Run controller for the multicycle CPU + rw_ram pair: generates the shared
// clock-enable strobe, sequences the CPU reset and watches the memory bus for
// a store to the tohost address, reporting pass / fail / timeout.
module cpu_test_ctrl #(
  parameter int unsigned CLK_DIV     = 1,
  parameter int unsigned RST_CYCLES  = 2,
  parameter logic [31:0] TOHOST_ADDR = 32'h0000_0FFC,
  parameter int unsigned TIMEOUT     = 100000,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk_100M,
  input  logic             rst,
  input  logic             start,
  input  logic             wr_en,
  input  logic [31:0]      mem_addr,
  input  logic [31:0]      w_data,
  output logic             clk_en,
  output logic             cpu_rst,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic             timeout,
  output logic [30:0]      fail_code,
  output logic [CNT_W-1:0] cycle_count
);

  localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned RC_W  = $clog2(RST_CYCLES + 1);
  localparam int unsigned TO_W  = $clog2(TIMEOUT + 1);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [RC_W-1:0]  RC_LAST  = RC_W'(RST_CYCLES - 1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RESET,
    S_RUN,
    S_DONE,
    S_TOUT
  } state_t;

  state_t             state_q;
  logic [DIV_W-1:0]   div_q;
  logic [RC_W-1:0]    rst_cnt_q;
  logic [TO_W-1:0]    run_cnt_q;
  logic               clk_en_q;
  logic               cpu_rst_q;
  logic               busy_q;
  logic               done_q;
  logic               pass_q;
  logic               timeout_q;
  logic [30:0]        fail_code_q;
  logic [CNT_W-1:0]   cycle_count_q;
  logic [CNT_W-1:0]   cycle_count_d;

  logic tick;
  logic ev;
  logic frozen;

  assign tick   = (div_q == '0);
  assign frozen = (state_q == S_DONE) || (state_q == S_TOUT);

  // A tohost store only counts when the RAM actually commits it (enable high).
  assign ev = clk_en_q & wr_en & (mem_addr == TOHOST_ADDR);

  // Saturating increment so a very long run never wraps back to a small count.
  assign cycle_count_d = (&cycle_count_q) ? cycle_count_q : cycle_count_q + CNT_W'(1);

  // Free-running divider; parked at zero while frozen so a restart begins with a tick.
  always_ff @(posedge clk_100M or posedge rst) begin
    if (rst) begin
      div_q <= '0;
    end else if (frozen || (div_q == DIV_LAST)) begin
      div_q <= '0;
    end else begin
      div_q <= div_q + DIV_W'(1);
    end
  end

  // Run sequencer with all outputs registered alongside the state.
  always_ff @(posedge clk_100M or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      clk_en_q      <= 1'b0;
      cpu_rst_q     <= 1'b1;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      pass_q        <= 1'b0;
      timeout_q     <= 1'b0;
      fail_code_q   <= '0;
      cycle_count_q <= '0;
      rst_cnt_q     <= '0;
      run_cnt_q     <= '0;
    end else begin
      clk_en_q <= tick;
      case (state_q)
        S_IDLE: begin
          cpu_rst_q <= 1'b1;
          busy_q    <= 1'b0;
          if (start) begin
            state_q       <= S_RESET;
            busy_q        <= 1'b1;
            done_q        <= 1'b0;
            pass_q        <= 1'b0;
            timeout_q     <= 1'b0;
            fail_code_q   <= '0;
            cycle_count_q <= '0;
            rst_cnt_q     <= '0;
            run_cnt_q     <= '0;
          end
        end

        S_RESET: begin
          cpu_rst_q <= 1'b1;
          busy_q    <= 1'b1;
          if (clk_en_q) begin
            if (rst_cnt_q == RC_LAST) begin
              state_q   <= S_RUN;
              cpu_rst_q <= 1'b0;
            end else begin
              rst_cnt_q <= rst_cnt_q + RC_W'(1);
            end
          end
        end

        S_RUN: begin
          cpu_rst_q <= 1'b0;
          busy_q    <= 1'b1;
          if (clk_en_q) begin
            cycle_count_q <= cycle_count_d;
            run_cnt_q     <= run_cnt_q + TO_W'(1);
            // The store wins over a timeout landing on the same tick.
            if (ev) begin
              state_q     <= S_DONE;
              busy_q      <= 1'b0;
              done_q      <= 1'b1;
              pass_q      <= (w_data == 32'd1);
              fail_code_q <= w_data[31:1];
              clk_en_q    <= 1'b0;
            end else if (run_cnt_q == TO_LAST) begin
              state_q   <= S_TOUT;
              busy_q    <= 1'b0;
              timeout_q <= 1'b1;
              clk_en_q  <= 1'b0;
            end
          end
        end

        S_DONE, S_TOUT: begin
          // CPU and RAM stay frozen (no enable, no reset) so their state can be inspected.
          cpu_rst_q <= 1'b0;
          busy_q    <= 1'b0;
          clk_en_q  <= 1'b0;
          if (start) begin
            state_q       <= S_RESET;
            cpu_rst_q     <= 1'b1;
            busy_q        <= 1'b1;
            clk_en_q      <= tick;
            done_q        <= 1'b0;
            pass_q        <= 1'b0;
            timeout_q     <= 1'b0;
            fail_code_q   <= '0;
            cycle_count_q <= '0;
            rst_cnt_q     <= '0;
            run_cnt_q     <= '0;
          end
        end

        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign clk_en      = clk_en_q;
  assign cpu_rst     = cpu_rst_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign pass        = pass_q;
  assign timeout     = timeout_q;
  assign fail_code   = fail_code_q;
  assign cycle_count = cycle_count_q;

endmodule

// File: tb/tb_cpu_test_ctrl.sv
// Directed bench for cpu_test_ctrl: one instance with a divide-by-1 enable and
// one with divide-by-4; run results are predicted into a queue when the
// program stimulus is issued and checked when done/timeout rises.
`timescale 1ns/1ps
module tb_cpu_test_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start_a = 1'b0;
  logic        start_b = 1'b0;
  logic        wr_en = 1'b0;
  logic [31:0] mem_addr = 32'h0;
  logic [31:0] w_data = 32'h0;

  logic        clk_en_a, cpu_rst_a, busy_a, done_a, pass_a, timeout_a;
  logic [30:0] fail_a;
  logic [31:0] cc_a;
  logic        clk_en_b, cpu_rst_b, busy_b, done_b, pass_b, timeout_b;
  logic [30:0] fail_b;
  logic [31:0] cc_b;

  always #5 clk = ~clk;

  cpu_test_ctrl #(.CLK_DIV(1), .RST_CYCLES(2), .TOHOST_ADDR(32'h0000_0FFC),
                  .TIMEOUT(50), .CNT_W(32)) u_a (
    .clk_100M(clk), .rst(rst), .start(start_a), .wr_en(wr_en),
    .mem_addr(mem_addr), .w_data(w_data), .clk_en(clk_en_a), .cpu_rst(cpu_rst_a),
    .busy(busy_a), .done(done_a), .pass(pass_a), .timeout(timeout_a),
    .fail_code(fail_a), .cycle_count(cc_a));

  cpu_test_ctrl #(.CLK_DIV(4), .RST_CYCLES(2), .TOHOST_ADDR(32'h0000_0FFC),
                  .TIMEOUT(50), .CNT_W(32)) u_b (
    .clk_100M(clk), .rst(rst), .start(start_b), .wr_en(wr_en),
    .mem_addr(mem_addr), .w_data(w_data), .clk_en(clk_en_b), .cpu_rst(cpu_rst_b),
    .busy(busy_b), .done(done_b), .pass(pass_b), .timeout(timeout_b),
    .fail_code(fail_b), .cycle_count(cc_b));

  // Selected-instance view used by the shared tasks.
  logic        sel = 1'b0;
  logic        clk_en_s, cpu_rst_s, busy_s, done_s, pass_s, timeout_s;
  logic [30:0] fail_s;
  logic [31:0] cc_s;
  assign clk_en_s  = sel ? clk_en_b  : clk_en_a;
  assign cpu_rst_s = sel ? cpu_rst_b : cpu_rst_a;
  assign busy_s    = sel ? busy_b    : busy_a;
  assign done_s    = sel ? done_b    : done_a;
  assign pass_s    = sel ? pass_b    : pass_a;
  assign timeout_s = sel ? timeout_b : timeout_a;
  assign fail_s    = sel ? fail_b    : fail_a;
  assign cc_s      = sel ? cc_b      : cc_a;

  typedef struct packed {
    logic        done;
    logic        pass;
    logic        timeout;
    logic [30:0] fail;
    logic [31:0] cnt;
  } res_t;

  res_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  int   tc = 0;    // clk_en ticks seen since RUN began

  localparam logic [95:0] RST_VEC = 96'({1'b0, 1'b1, 67'b0});

  function automatic logic [95:0] outs_a();
    return 96'({clk_en_a, cpu_rst_a, busy_a, done_a, pass_a, timeout_a, fail_a, cc_a});
  endfunction

  function automatic logic [95:0] outs_b();
    return 96'({clk_en_b, cpu_rst_b, busy_b, done_b, pass_b, timeout_b, fail_b, cc_b});
  endfunction

  task automatic chk(input string tag, input logic [95:0] got, input logic [95:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
    $display("check %-14s got %0h expected %0h", tag, got, exp);
  endtask

  // Pulse start, then follow the reset phase until cpu_rst drops.
  task automatic start_run(input string tag);
    int rc = 0;
    int guard = 0;
    logic busy_bad = 1'b0;
    @(negedge clk);
    if (sel) start_b = 1'b1; else start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    start_b = 1'b0;
    chk({tag, "_clr"}, 96'({done_s, pass_s, timeout_s, fail_s, cc_s}), 96'(0));
    while (cpu_rst_s && guard < 200) begin
      if (!busy_s) busy_bad = 1'b1;
      if (clk_en_s) rc++;
      @(negedge clk);
      guard++;
    end
    chk({tag, "_rstticks"}, 96'(rc), 96'(2));
    chk({tag, "_busy"}, 96'({busy_bad, busy_s}), 96'(1));
    tc = clk_en_s ? 1 : 0;
  endtask

  task automatic tick_wait(input int k);
    int seen = 0;
    int guard = 0;
    while (seen < k && guard < 2000) begin
      @(negedge clk);
      guard++;
      if (clk_en_s) begin
        seen++;
        tc++;
      end
    end
    if (seen < k) chk("tick_wait_tmo", 96'(seen), 96'(k));
  endtask

  // Issue a store during RUN tick n (n must exceed the ticks already seen).
  task automatic store_at(input int n, input logic [31:0] addr, input logic [31:0] data);
    tick_wait(n - tc);
    wr_en    = 1'b1;
    mem_addr = addr;
    w_data   = data;
    @(negedge clk);
    wr_en    = 1'b0;
    mem_addr = 32'h0;
  endtask

  task automatic wait_result(input string tag);
    int   guard = 0;
    res_t got;
    res_t exp;
    while (!(done_s || timeout_s) && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    if (!(done_s || timeout_s)) begin
      chk({tag, "_tmo"}, 96'({done_s, timeout_s}), 96'(1));
    end else if (exp_q.size() == 0) begin
      chk({tag, "_noexp"}, 96'(exp_q.size()), 96'(1));
    end else begin
      exp = exp_q.pop_front();
      got = '{done: done_s, pass: pass_s, timeout: timeout_s, fail: fail_s, cnt: cc_s};
      chk(tag, 96'(got), 96'(exp));
      chk({tag, "_idle"}, 96'({busy_s, cpu_rst_s, clk_en_s}), 96'(0));
    end
  endtask

  task automatic check_frozen(input string tag, input logic [31:0] cnt);
    logic any_en = 1'b0;
    logic cnt_moved = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (clk_en_s) any_en = 1'b1;
      if (cc_s !== cnt) cnt_moved = 1'b1;
    end
    chk(tag, 96'({any_en, cnt_moved}), 96'(0));
  endtask

  initial begin
    // Reset values while rst is held.
    @(negedge clk);
    chk("rst_a", outs_a(), RST_VEC);
    chk("rst_b", outs_b(), RST_VEC);
    #12;                      // t = 22 ns
    rst = 1'b0;
    @(negedge clk);
    chk("clken_first", 96'(clk_en_a), 96'(1));

    // Passing program: stores 1 on tick 10.
    sel = 1'b0;
    start_run("run1");
    exp_q.push_back('{done: 1'b1, pass: 1'b1, timeout: 1'b0, fail: 31'd0, cnt: 32'd10});
    store_at(10, 32'h0000_0FFC, 32'd1);
    wait_result("pass10");
    check_frozen("frozen1", 32'd10);

    // Failing program started from DONE: stores 0xB on tick 7.
    start_run("run2");
    exp_q.push_back('{done: 1'b1, pass: 1'b0, timeout: 1'b0, fail: 31'd5, cnt: 32'd7});
    store_at(7, 32'h0000_0FFC, 32'h0000_000B);
    wait_result("fail5");

    // No tohost store (a store elsewhere is ignored): timeout after 50 ticks.
    start_run("run3");
    exp_q.push_back('{done: 1'b0, pass: 1'b0, timeout: 1'b1, fail: 31'd0, cnt: 32'd50});
    store_at(5, 32'h0000_0FF8, 32'd1);
    wait_result("tout50");
    check_frozen("frozen3", 32'd50);

    // Tohost store on the timeout tick: the store wins.
    start_run("run4");
    exp_q.push_back('{done: 1'b1, pass: 1'b1, timeout: 1'b0, fail: 31'd0, cnt: 32'd50});
    store_at(50, 32'h0000_0FFC, 32'd1);
    wait_result("tie50");

    // rst mid-run: outputs return to reset values without waiting for a clock edge.
    start_run("run5");
    tick_wait(5);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_a", outs_a(), RST_VEC);
    chk("async_rst_b", outs_b(), RST_VEC);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Divide-by-4 instance.
    sel = 1'b1;
    start_run("runb");
    begin
      int highs = 0;
      for (int i = 0; i < 8; i++) begin
        @(negedge clk);
        if (clk_en_s) begin
          highs++;
          tc++;
        end
      end
      chk("div4_duty", 96'(highs), 96'(2));
    end
    // Store during an enable-low cycle must be ignored.
    tick_wait(1);
    @(negedge clk);
    wr_en    = 1'b1;
    mem_addr = 32'h0000_0FFC;
    w_data   = 32'd1;
    @(negedge clk);
    wr_en    = 1'b0;
    mem_addr = 32'h0;
    chk("div4_ignore", 96'({done_s, busy_s}), 96'(1));
    // The same store aligned with an enable tick ends the run.
    tick_wait(1);
    exp_q.push_back('{done: 1'b1, pass: 1'b1, timeout: 1'b0, fail: 31'd0, cnt: 32'(tc)});
    wr_en    = 1'b1;
    mem_addr = 32'h0000_0FFC;
    w_data   = 32'd1;
    @(negedge clk);
    wr_en    = 1'b0;
    mem_addr = 32'h0;
    wait_result("div4_done");
    chk("exp_q_empty", 96'(exp_q.size()), 96'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Absolute time limit so the bench always ends.
  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "time limit");
  end

endmodule
